// File: rtl/lc3_ctrl_seq.sv
// LC-3 control sequencer: Moore FSM driving datapath loads, bus gates, muxes and SRAM strobes.
// SRAM access length is MEM_WAIT+1 cycles, timed by one shared wait counter.
module lc3_ctrl_seq #(
  parameter int unsigned MEM_WAIT = 2,
  parameter bit          PAUSE_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic       i_continue,
  input  logic [3:0] i_opcode,
  input  logic       i_ir_5,
  input  logic       i_ir_11,
  input  logic       i_ben,
  output logic       o_ld_mar,
  output logic       o_ld_mdr,
  output logic       o_ld_ir,
  output logic       o_ld_ben,
  output logic       o_ld_cc,
  output logic       o_ld_reg,
  output logic       o_ld_pc,
  output logic       o_gate_pc,
  output logic       o_gate_mdr,
  output logic       o_gate_alu,
  output logic       o_gate_marmux,
  output logic [1:0] o_pcmux,
  output logic [1:0] o_drmux,
  output logic [1:0] o_sr1mux,
  output logic       o_sr2mux,
  output logic       o_addr1mux,
  output logic [1:0] o_addr2mux,
  output logic       o_marmux,
  output logic       o_mio_en,
  output logic [1:0] o_aluk,
  output logic       o_mem_ce,
  output logic       o_mem_ub,
  output logic       o_mem_lb,
  output logic       o_mem_oe,
  output logic       o_mem_we,
  output logic       o_halted
);

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101, OP_LEA = 4'b1110, OP_TRP = 4'b1111;

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH, S_FETCH_RD, S_LD_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR0, S_BR_TAKE, S_JMP, S_JSR0, S_JSR1, S_LEA,
    S_ADDR_PC, S_ADDR_BASE, S_RD, S_LDI_RD, S_LDI_MAR, S_WB,
    S_STI_RD, S_STI_MAR, S_WR_MDR, S_WR,
    S_TRAP0, S_TRAP_R7, S_TRAP_RD, S_TRAP_PC, S_PAUSE1, S_PAUSE2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt;
  logic       r_mem_oe, r_mem_we;
  logic       w_mem_done, w_in_rd, w_nxt_rd;

  assign w_mem_done = (r_cnt == 4'(MEM_WAIT));
  assign w_in_rd    = r_state inside {S_FETCH_RD, S_RD, S_LDI_RD, S_STI_RD, S_TRAP_RD};
  assign w_nxt_rd   = w_state_nxt inside {S_FETCH_RD, S_RD, S_LDI_RD, S_STI_RD, S_TRAP_RD};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_HALTED;
      r_cnt    <= '0;
      r_mem_oe <= 1'b1;
      r_mem_we <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= (w_state_nxt != r_state) ? 4'd0 : r_cnt + 4'd1;
      // SRAM strobes come straight from flops so they never glitch.
      r_mem_oe <= ~w_nxt_rd;
      r_mem_we <= ~(w_state_nxt == S_WR);
    end
  end

  // NOTE: next state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HALTED:   if (i_run) w_state_nxt = S_FETCH;
      S_FETCH:    w_state_nxt = S_FETCH_RD;
      S_FETCH_RD: if (w_mem_done) w_state_nxt = S_LD_IR;
      S_LD_IR:    w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_ADD:                 w_state_nxt = S_ADD;
          OP_AND:                 w_state_nxt = S_AND;
          OP_NOT:                 w_state_nxt = S_NOT;
          OP_BR:                  w_state_nxt = S_BR0;
          OP_JMP:                 w_state_nxt = S_JMP;
          OP_JSR:                 w_state_nxt = S_JSR0;
          OP_LEA:                 w_state_nxt = S_LEA;
          OP_LD, OP_LDI, OP_ST, OP_STI: w_state_nxt = S_ADDR_PC;
          OP_LDR, OP_STR:         w_state_nxt = S_ADDR_BASE;
          OP_TRP:                 w_state_nxt = S_TRAP0;
          OP_PSE:                 w_state_nxt = PAUSE_EN ? S_PAUSE1 : S_HALTED;
          default:                w_state_nxt = S_HALTED;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_JMP, S_LEA, S_JSR1, S_BR_TAKE, S_WB, S_TRAP_PC:
        w_state_nxt = S_FETCH;
      S_BR0:      w_state_nxt = i_ben ? S_BR_TAKE : S_FETCH;
      S_JSR0:     w_state_nxt = S_JSR1;
      S_ADDR_PC, S_ADDR_BASE: begin
        case (i_opcode)
          OP_LD, OP_LDR: w_state_nxt = S_RD;
          OP_LDI:        w_state_nxt = S_LDI_RD;
          OP_ST, OP_STR: w_state_nxt = S_WR_MDR;
          OP_STI:        w_state_nxt = S_STI_RD;
          default:       w_state_nxt = S_HALTED;
        endcase
      end
      S_RD:       if (w_mem_done) w_state_nxt = S_WB;
      S_LDI_RD:   if (w_mem_done) w_state_nxt = S_LDI_MAR;
      S_LDI_MAR:  w_state_nxt = S_RD;
      S_STI_RD:   if (w_mem_done) w_state_nxt = S_STI_MAR;
      S_STI_MAR:  w_state_nxt = S_WR_MDR;
      S_WR_MDR:   w_state_nxt = S_WR;
      S_WR:       if (w_mem_done) w_state_nxt = S_FETCH;
      S_TRAP0:    w_state_nxt = S_TRAP_R7;
      S_TRAP_R7:  w_state_nxt = S_TRAP_RD;
      S_TRAP_RD:  if (w_mem_done) w_state_nxt = S_TRAP_PC;
      S_PAUSE1:   if (i_continue) w_state_nxt = S_PAUSE2;
      S_PAUSE2:   if (!i_continue) w_state_nxt = S_FETCH;
      default:    w_state_nxt = S_HALTED;
    endcase
  end

  always_comb begin
    o_ld_mar = 1'b0; o_ld_mdr = 1'b0; o_ld_ir = 1'b0; o_ld_ben = 1'b0;
    o_ld_cc = 1'b0; o_ld_reg = 1'b0; o_ld_pc = 1'b0;
    o_gate_pc = 1'b0; o_gate_mdr = 1'b0; o_gate_alu = 1'b0; o_gate_marmux = 1'b0;
    o_pcmux = 2'b00; o_drmux = 2'b00; o_sr1mux = 2'b00; o_sr2mux = 1'b0;
    o_addr1mux = 1'b0; o_addr2mux = 2'b00; o_marmux = 1'b0; o_mio_en = 1'b0; o_aluk = 2'b00;
    if (w_in_rd) begin
      o_mio_en = 1'b1;
      o_ld_mdr = w_mem_done;
    end
    case (r_state)
      S_FETCH:   begin o_gate_pc = 1'b1; o_ld_mar = 1'b1; o_ld_pc = 1'b1; end
      S_LD_IR:   begin o_gate_mdr = 1'b1; o_ld_ir = 1'b1; end
      S_DECODE:  o_ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        o_sr1mux = 2'b01; o_gate_alu = 1'b1; o_ld_reg = 1'b1; o_ld_cc = 1'b1;
        o_aluk   = (r_state == S_ADD) ? 2'b00 : (r_state == S_AND) ? 2'b01 : 2'b10;
        o_sr2mux = (r_state != S_NOT) & i_ir_5;
      end
      S_BR_TAKE: begin o_addr2mux = 2'b10; o_pcmux = 2'b10; o_ld_pc = 1'b1; end
      S_JMP: begin
        o_sr1mux = 2'b01; o_aluk = 2'b11; o_gate_alu = 1'b1; o_pcmux = 2'b01; o_ld_pc = 1'b1;
      end
      S_JSR0, S_TRAP_R7: begin o_gate_pc = 1'b1; o_drmux = 2'b01; o_ld_reg = 1'b1; end
      S_JSR1: begin
        o_pcmux = 2'b10; o_ld_pc = 1'b1;
        if (i_ir_11) begin
          o_addr2mux = 2'b11;
        end else begin
          o_addr1mux = 1'b1; o_sr1mux = 2'b01;
        end
      end
      S_LEA:     begin o_addr2mux = 2'b10; o_gate_marmux = 1'b1; o_ld_reg = 1'b1; o_ld_cc = 1'b1; end
      S_ADDR_PC: begin o_addr2mux = 2'b10; o_gate_marmux = 1'b1; o_ld_mar = 1'b1; end
      S_ADDR_BASE: begin
        o_addr1mux = 1'b1; o_addr2mux = 2'b01; o_sr1mux = 2'b01;
        o_gate_marmux = 1'b1; o_ld_mar = 1'b1;
      end
      S_LDI_MAR, S_STI_MAR: begin o_gate_mdr = 1'b1; o_ld_mar = 1'b1; end
      S_WB:      begin o_gate_mdr = 1'b1; o_ld_reg = 1'b1; o_ld_cc = 1'b1; end
      S_WR_MDR:  begin o_aluk = 2'b11; o_gate_alu = 1'b1; o_ld_mdr = 1'b1; end
      S_TRAP0:   begin o_marmux = 1'b1; o_gate_marmux = 1'b1; o_ld_mar = 1'b1; end
      S_TRAP_PC: begin o_gate_mdr = 1'b1; o_pcmux = 2'b01; o_ld_pc = 1'b1; end
      default: ;
    endcase
  end

  assign o_mem_ce = 1'b0;
  assign o_mem_ub = 1'b0;
  assign o_mem_lb = 1'b0;
  assign o_mem_oe = r_mem_oe;
  assign o_mem_we = r_mem_we;
  assign o_halted = (r_state == S_HALTED);

endmodule
